tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 112 +++++++++++
 tb/tb_tmds_decoder.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// tmds_decoder: word-aligning TMDS channel decoder that locks on runs of identical
// control tokens and sweeps the bit offset until alignment is found.
module tmds_decoder #(
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int CTRL_RUN = 16,
    parameter int LOSS_TIMEOUT = 65536
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] raw_word,
    output logic [7:0] data_out,
    output logic       c0,
    output logic       c1,
    output logic       de,
    output logic       locked,
    output logic [3:0] bit_offset
);
    localparam int DW = $clog2(SEARCH_TIMEOUT + 1);
    localparam int RW = $clog2(CTRL_RUN + 1);
    localparam int LW = $clog2(LOSS_TIMEOUT + 1);
    localparam logic [DW-1:0] DWELL_END = DW'(SEARCH_TIMEOUT - 1);
    localparam logic [RW-1:0] RUN_MAX = RW'(CTRL_RUN);
    localparam logic [LW-1:0] LOSS_END = LW'(LOSS_TIMEOUT - 1);
    localparam logic [0:0] SEARCH = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]    state;
    logic [9:0]    prev_word;
    logic [9:0]    s1;
    logic          prev_valid;
    logic          s1_valid;
    logic [DW-1:0] dwell;
    logic [RW-1:0] run_cnt;
    logic [RW-1:0] run_next;
    logic [LW-1:0] loss;
    logic [1:0]    flush;
    logic [1:0]    last_tok;
    logic [9:0]    w;
    logic          is_tok;
    logic          tok;
    logic [1:0]    tok_val;
    logic [7:0]    q;
    logic [7:0]    d;
    logic          run_full;
    logic          adv;
    logic [3:0]    next_off;

    assign w = 10'({raw_word, prev_word} >> bit_offset);

    always_comb begin
        is_tok = 1'b1;
        tok_val = 2'b00;
        case (s1)
            10'b1101010100: tok_val = 2'b00;
            10'b0010101011: tok_val = 2'b01;
            10'b0101010100: tok_val = 2'b10;
            10'b1010101011: tok_val = 2'b11;
            default:        is_tok = 1'b0;
        endcase
    end

    assign tok = is_tok & s1_valid;
    assign q = s1[9] ? ~s1[7:0] : s1[7:0];
    assign d = {s1[8] ? q[7:1] ^ q[6:0] : ~(q[7:1] ^ q[6:0]), q[0]};

    assign run_full = run_cnt == RUN_MAX;
    assign run_next = !tok ? '0 :
                      (run_cnt != '0 && tok_val == last_tok) ? (run_full ? run_cnt : run_cnt + RW'(1)) :
                      RW'(1);
    // Lock completion always wins over a coinciding timeout
    assign adv = !run_full && (state == SEARCH ? dwell == DWELL_END : loss == LOSS_END);
    assign next_off = bit_offset == 4'd9 ? 4'd0 : bit_offset + 4'd1;
    assign locked = state == LOCKED;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH;
            bit_offset <= 4'd0;
            prev_word <= 10'd0;
            s1 <= 10'd0;
            prev_valid <= 1'b0;
            s1_valid <= 1'b0;
            de <= 1'b0;
            c0 <= 1'b0;
            c1 <= 1'b0;
            data_out <= 8'd0;
            dwell <= '0;
            run_cnt <= '0;
            loss <= '0;
            flush <= 2'd0;
            last_tok <= 2'd0;
        end else begin
            prev_word <= raw_word;
            prev_valid <= 1'b1;
            s1 <= w;
            s1_valid <= prev_valid;
            if (s1_valid) begin
                de <= !tok;
                data_out <= tok ? 8'd0 : d;
                if (tok) {c1, c0} <= tok_val;
            end
            if (tok) last_tok <= tok_val;
            // The two words after an offset change were framed at the old offset
            run_cnt <= (flush != 2'd0 || adv) ? '0 : run_next;
            flush <= adv ? 2'd2 : (flush != 2'd0 ? flush - 2'd1 : 2'd0);
            if (adv) bit_offset <= next_off;
            state <= state == SEARCH ? (run_full ? LOCKED : SEARCH) : (adv ? SEARCH : LOCKED);
            dwell <= (state != SEARCH || adv || run_full) ? '0 : dwell + DW'(1);
            loss <= (state != LOCKED || adv || run_full) ? '0 : loss + LW'(1);
        end
    end
endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: bit-serial stream generator with TMDS reference encoder and
// an output scoreboard that checks decoded words whenever the decoder reports lock.
module tb_tmds_decoder;
    localparam int ST = 64;
    localparam int CR = 16;
    localparam int LT = 300;

    typedef struct packed {
        logic       de;
        logic [1:0] c;
        logic [7:0] data;
        logic       chk_c;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] raw_word = 10'd0;
    logic [7:0] data_out;
    logic       c0, c1, de, locked;
    logic [3:0] bit_offset;

    exp_t eq[$];
    bit   bq[$];
    exp_t e;
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   disp = 0;
    int   mn = 0;
    logic [1:0] last_c = 2'b00;
    logic mrst;

    tmds_decoder #(.SEARCH_TIMEOUT(ST), .CTRL_RUN(CR), .LOSS_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset), .raw_word(raw_word), .data_out(data_out),
        .c0(c0), .c1(c1), .de(de), .locked(locked), .bit_offset(bit_offset)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [9:0] tok_word(input logic [1:0] v);
        case (v)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic int ones(input logic [7:0] x);
        int n = 0;
        for (int i = 0; i < 8; i++) n += int'(x[i]);
        return n;
    endfunction

    function automatic logic [9:0] encode(input logic [7:0] b);
        logic [8:0] qm;
        logic       xn;
        logic [9:0] o;
        int n1, n0;
        n1 = ones(b);
        xn = n1 > 4 || (n1 == 4 && !b[0]);
        qm[0] = b[0];
        for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ b[i]) : qm[i-1] ^ b[i];
        qm[8] = !xn;
        n1 = ones(qm[7:0]);
        n0 = 8 - n1;
        if (disp == 0 || n1 == n0) begin
            o = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
            disp += qm[8] ? n1 - n0 : n0 - n1;
        end else if ((disp > 0 && n1 > n0) || (disp < 0 && n0 > n1)) begin
            o = {1'b1, qm[8], ~qm[7:0]};
            disp += 2 * int'(qm[8]) + n0 - n1;
        end else begin
            o = {1'b0, qm[8], qm[7:0]};
            disp += -2 * int'(!qm[8]) + n1 - n0;
        end
        return o;
    endfunction

    task automatic push_bits(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) bq.push_back(w[i]);
    endtask

    task automatic add_tok(input logic [1:0] v, input int n, input logic chk);
        exp_t x;
        repeat (n) begin
            push_bits(tok_word(v), 10);
            last_c = v;
            x.de = 1'b0; x.c = v; x.data = 8'h00; x.chk_c = chk;
            eq.push_back(x);
        end
    endtask

    task automatic add_data(input logic [7:0] b, input logic chk);
        exp_t x;
        push_bits(encode(b), 10);
        x.de = 1'b1; x.c = last_c; x.data = b; x.chk_c = chk;
        eq.push_back(x);
    endtask

    task automatic tick;
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            if (bq.size() > 0) raw_word[i] = bq.pop_front();
            else raw_word[i] = 1'b0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        bq.delete();
        eq.delete();
        disp = 0;
        last_c = 2'b00;
        tick;
        tick;
        reset = 1'b0;
        cyc = 0;
    endtask

    // Word j of the stream leaves the decoder on the third edge after reset plus j
    always begin
        @(posedge clk);
        mrst = reset;
        #1;
        mn = mrst ? 0 : mn + 1;
        if (mn >= 3 && eq.size() > 0) begin
            e = eq.pop_front();
            if (locked) begin
                tests++;
                if (de !== e.de || data_out !== e.data || ((!e.de || e.chk_c) && {c1, c0} !== e.c)) begin
                    fails++;
                    $display("FAIL scoreboard: got de=%b c=%b data=%h, expected de=%b c=%b data=%h",
                             de, {c1, c0}, data_out, e.de, e.c, e.data);
                end
            end
        end
    end

    task automatic test_reset;
        do_reset;
        tests++;
        if ({locked, bit_offset, de, c1, c0, data_out} !== 16'd0) begin
            fails++;
            $display("FAIL reset_state: got locked=%b off=%0d de=%b c=%b data=%h, expected all 0",
                     locked, bit_offset, de, {c1, c0}, data_out);
        end
        for (int i = 0; i < 10; i++) add_data(8'(8'h5A + i), 1'b1);
        tick;
        tick;
        tests++;
        if (de !== 1'b0 || data_out !== 8'h00) begin
            fails++;
            $display("FAIL reset_no_early_decode: got de=%b data=%h, expected 0/00", de, data_out);
        end
        tick;
        tests++;
        if (de !== 1'b1 || data_out !== 8'h5A) begin
            fails++;
            $display("FAIL first_decode: got de=%b data=%h, expected 1/5a", de, data_out);
        end
    endtask

    task automatic test_aligned;
        do_reset;
        add_tok(2'b00, 20, 1'b1);
        for (int b = 0; b < 256; b++) add_data(8'(b), 1'b1);
        for (int k = 0; k < 400 && eq.size() > 0; k++) begin
            tick;
            if (cyc == 18) begin
                tests++;
                if (locked !== 1'b0) begin fails++; $display("FAIL aligned_early_lock: got %b, expected 0", locked); end
            end
            if (cyc == 19) begin
                tests++;
                if (locked !== 1'b1 || bit_offset !== 4'd0) begin
                    fails++;
                    $display("FAIL aligned_lock: got locked=%b off=%0d, expected 1/0", locked, bit_offset);
                end
            end
        end
        tests++;
        if (eq.size() != 0 || locked !== 1'b1) begin
            fails++;
            $display("FAIL aligned_drain: got pending=%0d locked=%b, expected 0/1", eq.size(), locked);
        end
    endtask

    task automatic test_controls;
        logic [1:0] want;
        do_reset;
        for (int v = 0; v < 4; v++) add_tok(2'(v), 20, 1'b1);
        for (int i = 0; i < 8; i++) add_data(8'(8'hC3 ^ i), 1'b1);
        for (int k = 0; k < 200 && eq.size() > 0; k++) begin
            tick;
            if (cyc == 28 || cyc == 48 || cyc == 68) begin
                want = 2'((cyc - 8) / 20);
                tests++;
                if ({c1, c0} !== want || de !== 1'b0 || locked !== 1'b1) begin
                    fails++;
                    $display("FAIL ctrl_value: got c=%b de=%b locked=%b, expected c=%b de=0 locked=1",
                             {c1, c0}, de, locked, want);
                end
            end
            if (cyc == 88) begin
                tests++;
                if ({c1, c0} !== 2'b11 || de !== 1'b1 || data_out !== (8'hC3 ^ 8'd5)) begin
                    fails++;
                    $display("FAIL ctrl_hold: got c=%b de=%b data=%h, expected 11/1/c6", {c1, c0}, de, data_out);
                end
            end
        end
    endtask

    task automatic test_short_run;
        bit seen;
        do_reset;
        add_tok(2'b00, CR - 1, 1'b1);
        for (int i = 0; i < 40; i++) add_data(8'($urandom), 1'b1);
        seen = 0;
        repeat (60) begin
            tick;
            seen |= locked;
        end
        tests++;
        if (seen) begin fails++; $display("FAIL short_run: got locked=1, expected no lock from %0d tokens", CR - 1); end
        do_reset;
        add_tok(2'b00, CR, 1'b1);
        for (int i = 0; i < 40; i++) add_data(8'($urandom), 1'b1);
        repeat (60) begin
            tick;
            if (cyc == 18 || cyc == 19) begin
                tests++;
                if (locked !== (cyc == 19)) begin
                    fails++;
                    $display("FAIL exact_run cyc %0d: got locked=%b, expected %b", cyc, locked, cyc == 19);
                end
            end
        end
    endtask

    task automatic test_skew7;
        do_reset;
        push_bits(10'($urandom), 7);
        add_tok(2'b00, 8 * ST, 1'b0);
        for (int b = 0; b < 256; b++) add_data(8'(b), 1'b0);
        for (int k = 0; k < 8 * ST + 400 && eq.size() > 0; k++) begin
            tick;
            if (cyc % ST == 0 && cyc <= 7 * ST) begin
                tests++;
                if (bit_offset !== 4'(cyc / ST) || locked !== 1'b0) begin
                    fails++;
                    $display("FAIL skew7_step cyc %0d: got off=%0d locked=%b, expected %0d/0",
                             cyc, bit_offset, locked, cyc / ST);
                end
            end
            if (cyc == 7 * ST + 19) begin
                tests++;
                if (locked !== 1'b1 || bit_offset !== 4'd7) begin
                    fails++;
                    $display("FAIL skew7_lock: got locked=%b off=%0d, expected 1/7", locked, bit_offset);
                end
            end
        end
        tests++;
        if (eq.size() != 0 || locked !== 1'b1 || bit_offset !== 4'd7) begin
            fails++;
            $display("FAIL skew7_end: got pending=%0d locked=%b off=%0d, expected 0/1/7", eq.size(), locked, bit_offset);
        end
    endtask

    task automatic test_skew9_coincide;
        do_reset;
        push_bits(10'($urandom), 9);
        for (int j = 0; j < 10 * ST - 19; j++) add_data(8'($urandom), 1'b0);
        add_tok(2'b00, 40, 1'b0);
        for (int i = 0; i < 32; i++) add_data(8'($urandom), 1'b0);
        for (int k = 0; k < 11 * ST + 200 && eq.size() > 0; k++) begin
            tick;
            if (cyc == 10 * ST - 1 || cyc == 10 * ST) begin
                tests++;
                if (bit_offset !== 4'd9 || locked !== (cyc == 10 * ST)) begin
                    fails++;
                    $display("FAIL skew9_coincide cyc %0d: got off=%0d locked=%b, expected 9/%b",
                             cyc, bit_offset, locked, cyc == 10 * ST);
                end
            end
        end
        tests++;
        if (locked !== 1'b1 || bit_offset !== 4'd9) begin
            fails++;
            $display("FAIL skew9_end: got locked=%b off=%0d, expected 1/9", locked, bit_offset);
        end
    endtask

    task automatic test_loss;
        do_reset;
        add_tok(2'b00, 20, 1'b1);
        for (int i = 0; i < LT + 40; i++) add_data(8'($urandom), 1'b1);
        for (int k = 0; k < LT + 100 && eq.size() > 0; k++) begin
            tick;
            if (cyc == LT + 22 || cyc == LT + 23) begin
                tests++;
                if (locked !== (cyc == LT + 22) || bit_offset !== 4'(cyc == LT + 23)) begin
                    fails++;
                    $display("FAIL loss_drop cyc %0d: got locked=%b off=%0d, expected %b/%0d",
                             cyc, locked, bit_offset, cyc == LT + 22, cyc == LT + 23);
                end
            end
        end
    endtask

    task automatic test_reset_locked;
        do_reset;
        add_tok(2'b11, 20, 1'b1);
        for (int i = 0; i < 40; i++) add_data(8'($urandom), 1'b1);
        repeat (30) tick;
        tests++;
        if (locked !== 1'b1 || {c1, c0} !== 2'b11) begin
            fails++;
            $display("FAIL pre_reset: got locked=%b c=%b, expected 1/11", locked, {c1, c0});
        end
        reset = 1'b1;
        bq.delete();
        eq.delete();
        tick;
        reset = 1'b0;
        tests++;
        if ({locked, bit_offset, de, c1, c0, data_out} !== 16'd0) begin
            fails++;
            $display("FAIL reset_pulse: got locked=%b off=%0d de=%b c=%b data=%h, expected all 0",
                     locked, bit_offset, de, {c1, c0}, data_out);
        end
        cyc = 0;
        disp = 0;
        last_c = 2'b00;
        for (int i = 0; i < 10; i++) add_data(8'(8'h81 + i), 1'b1);
        repeat (2) begin
            tick;
            tests++;
            if (de !== 1'b0 || data_out !== 8'h00 || locked !== 1'b0) begin
                fails++;
                $display("FAIL post_reset_quiet cyc %0d: got de=%b data=%h locked=%b, expected 0/00/0",
                         cyc, de, data_out, locked);
            end
        end
        tick;
        tests++;
        if (de !== 1'b1 || data_out !== 8'h81) begin
            fails++;
            $display("FAIL post_reset_decode: got de=%b data=%h, expected 1/81", de, data_out);
        end
    endtask

    initial begin
        test_reset;
        test_aligned;
        test_controls;
        test_short_run;
        test_skew7;
        test_skew9_coincide;
        test_loss;
        test_reset_locked;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
